memory_arbiter: RTL

- Shares the single memory_controller port (one RAM access per cycle, synchronous read) between two requesters.
  - Port 0: evaluator/CPU.
  - Port 1: cons allocator / garbage collector.
- Holds off all traffic until boot completes, then arbitrates round-robin with a valid/ready handshake and returns read data to the issuing port.
- Latches memory errors and blocks all further traffic.

---
 rtl/memory_arbiter_if.sv | 52 +++++
 rtl/memory_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the memory controller.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   logic                  req0_valid;
   logic                  req0_write;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_wdata;
   logic                  req0_ready;
   logic                  req0_rvalid;
   logic [DATA_WIDTH-1:0] req0_rdata;

   logic                  req1_valid;
   logic                  req1_write;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_wdata;
   logic                  req1_ready;
   logic                  req1_rvalid;
   logic [DATA_WIDTH-1:0] req1_rdata;

   logic                  mem_boot_done;
   logic                  mem_memory_error;
   logic                  mem_write_enable;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic [DATA_WIDTH-1:0] mem_read_data;

   logic                  arb_busy;
   logic                  arb_error;

   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, req0_rvalid, req0_rdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, req1_rvalid, req1_rdata,
      input  mem_boot_done, mem_memory_error, mem_read_data,
      output mem_write_enable, mem_addr, mem_write_data,
      output arb_busy, arb_error
   );

   modport master (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, req0_rvalid, req0_rdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, req1_rvalid, req1_rdata,
      output mem_boot_done, mem_memory_error, mem_read_data,
      input  mem_write_enable, mem_addr, mem_write_data,
      input  arb_busy, arb_error
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of the single-ported memory controller.
// Reads take two cycles (address, then capture); writes sustain one per cycle.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   memory_arbiter_if.slave  bus
);
   typedef enum logic [2:0] {
      WAIT_BOOT = 3'd0,
      IDLE      = 3'd1,
      READ_WAIT = 3'd2,
      ERROR     = 3'd3
   } state_t;

   state_t                state_q;
   logic                  last_grant_q;
   logic                  owner_q;
   logic [ADDR_WIDTH-1:0] rd_addr_q;
   logic [1:0]            rvalid_q;
   logic [DATA_WIDTH-1:0] rdata0_q;
   logic [DATA_WIDTH-1:0] rdata1_q;

   logic                  grant;
   logic                  winner;
   logic                  win_write;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   // On a tie the port that did not win last time goes first.
   always_comb begin
      grant     = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);
      winner    = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
      win_write = winner ? bus.req1_write : bus.req0_write;
      win_addr  = winner ? bus.req1_addr  : bus.req0_addr;
      win_wdata = winner ? bus.req1_wdata : bus.req0_wdata;
   end

   always_comb begin
      bus.mem_write_enable = 1'b0;
      bus.mem_addr         = '0;
      bus.mem_write_data   = '0;
      if (grant) begin
         bus.mem_write_enable = win_write;
         bus.mem_addr         = win_addr;
         bus.mem_write_data   = win_wdata;
      end else if (state_q == READ_WAIT) begin
         bus.mem_addr = rd_addr_q;
      end
   end

   assign bus.req0_ready  = grant && !winner;
   assign bus.req1_ready  = grant && winner;
   assign bus.req0_rvalid = rvalid_q[0];
   assign bus.req1_rvalid = rvalid_q[1];
   assign bus.req0_rdata  = rdata0_q;
   assign bus.req1_rdata  = rdata1_q;
   assign bus.arb_busy    = (state_q == READ_WAIT);
   assign bus.arb_error   = (state_q == ERROR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_BOOT;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         rd_addr_q    <= '0;
         rvalid_q     <= 2'b00;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         rvalid_q <= 2'b00;
         // A memory error preempts everything, including a read in flight.
         if (bus.mem_memory_error) begin
            state_q <= ERROR;
         end else begin
            case (state_q)
               WAIT_BOOT: begin
                  if (bus.mem_boot_done) state_q <= IDLE;
               end
               IDLE: begin
                  if (grant) begin
                     last_grant_q <= winner;
                     if (!win_write) begin
                        rd_addr_q <= win_addr;
                        owner_q   <= winner;
                        state_q   <= READ_WAIT;
                     end
                  end
               end
               READ_WAIT: begin
                  if (owner_q) rdata1_q <= bus.mem_read_data;
                  else         rdata0_q <= bus.mem_read_data;
                  rvalid_q[owner_q] <= 1'b1;
                  state_q           <= IDLE;
               end
               ERROR:   state_q <= ERROR;
               default: state_q <= ERROR;
            endcase
         end
      end
   end
endmodule
